reset_request_sequencer: RTL and testbench



---
 rtl/reset_request_sequencer_pkg.sv | 8 +
 rtl/reset_req_sync.sv | 15 +
 rtl/reset_request_sequencer.sv | 91 +++++++++
 tb/tb_reset_request_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/reset_request_sequencer_pkg.sv
// reset_request_sequencer_pkg: sequencer state encoding and sticky cause bit positions.
package reset_request_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, QUIESCE, ASSERT, RELEASE} state_t;
    localparam int CAUSE_SW   = 0;
    localparam int CAUSE_WDOG = 1;
    localparam int CAUSE_DBG  = 2;
    localparam int CAUSE_TMO  = 3;
endpackage

// File: rtl/reset_req_sync.sv
// reset_req_sync: multi-flop level synchronizer for an asynchronous input.
module reset_req_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clock or posedge reset)
        if (reset) ff <= '0;
        else ff <= {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/reset_request_sequencer.sv
// reset_request_sequencer: gathers reset requests, quiesces the bus, drives a
// minimum-width reset into the reset tree and tracks its assert/release handshake.
module reset_request_sequencer
    import reset_request_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 64,
    parameter int QUIESCE_TIMEOUT = 1024,
    parameter int CNT_W           = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sw_req,
    input  logic       wdog_req,
    input  logic       dbg_req,
    output logic       quiesce_req,
    input  logic       quiesce_ack,
    output logic       areset_out,
    input  logic       tree_reset,
    output logic       busy,
    output logic [3:0] cause,
    input  logic       cause_clr
);
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic wdog_s, dbg_s, tree_s, wdog_d, dbg_d;
    logic wdog_edge, dbg_edge, ev, tmo;
    logic [3:0] set;

    reset_req_sync #(.STAGES(SYNC_STAGES)) u_wdog (.clock(clock), .reset(reset), .d(wdog_req), .q(wdog_s));
    reset_req_sync #(.STAGES(SYNC_STAGES)) u_dbg (.clock(clock), .reset(reset), .d(dbg_req), .q(dbg_s));
    reset_req_sync #(.STAGES(SYNC_STAGES)) u_tree (.clock(clock), .reset(reset), .d(tree_reset), .q(tree_s));

    assign wdog_edge = wdog_s & ~wdog_d;
    assign dbg_edge  = dbg_s & ~dbg_d;
    assign ev        = sw_req | wdog_edge | dbg_edge;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (ev) state_nxt = QUIESCE;
            end
            QUIESCE:
                if (quiesce_ack || cnt == CNT_W'(QUIESCE_TIMEOUT - 1)) begin
                    state_nxt = ASSERT;
                    cnt_nxt   = '0;
                    tmo       = ~quiesce_ack;
                end else cnt_nxt = cnt + CNT_W'(1);
            // counter parks at HOLD_CYCLES-1 until the tree confirms it is in reset
            ASSERT:
                if (cnt != CNT_W'(HOLD_CYCLES - 1)) cnt_nxt = cnt + CNT_W'(1);
                else if (tree_s) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end
            RELEASE:
                if (!tree_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        set            = '0;
        set[CAUSE_SW]   = sw_req;
        set[CAUSE_WDOG] = wdog_edge;
        set[CAUSE_DBG]  = dbg_edge;
        set[CAUSE_TMO]  = tmo;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            wdog_d      <= 1'b0;
            dbg_d       <= 1'b0;
            quiesce_req <= 1'b0;
            areset_out  <= 1'b0;
            busy        <= 1'b0;
            cause       <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            wdog_d      <= wdog_s;
            dbg_d       <= dbg_s;
            quiesce_req <= state_nxt == QUIESCE || state_nxt == ASSERT;
            areset_out  <= state_nxt == ASSERT;
            busy        <= state_nxt != IDLE;
            cause       <= (cause & ~{4{cause_clr}}) | set;
        end
endmodule

// File: tb/tb_reset_request_sequencer.sv
// tb_reset_request_sequencer: scoreboard bench with behavioural quiesce-ack and reset-tree models.
module tb_reset_request_sequencer;
    logic clock = 0, reset = 1, sw_req = 0, wdog_req = 0, dbg_req = 0, cause_clr = 0;
    logic quiesce_ack, tree_reset, quiesce_req, areset_out, busy;
    logic [3:0] cause;
    int ack_mode = 0;
    logic tree_auto = 1, tree_man = 0, ar_q = 0;
    logic [4:0] qdly = '0;
    logic [2:0] tdly = '0;
    int n_chk = 0, n_pass = 0, seqs = 0, s0, n;
    int sb[$];

    reset_request_sequencer dut (
        .clock(clock), .reset(reset), .sw_req(sw_req), .wdog_req(wdog_req), .dbg_req(dbg_req),
        .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack), .areset_out(areset_out),
        .tree_reset(tree_reset), .busy(busy), .cause(cause), .cause_clr(cause_clr)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        qdly <= {qdly[3:0], quiesce_req};
        tdly <= {tdly[1:0], areset_out};
        ar_q <= areset_out;
        if (areset_out && !ar_q) seqs <= seqs + 1;
    end
    assign quiesce_ack = ack_mode == 1 ? qdly[4] : ack_mode == 2;
    assign tree_reset  = tree_auto ? tdly[2] : tree_man;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic pop_check(input string tag, input int obs);
        check(tag, obs, sb.size() > 0 ? sb.pop_front() : -999);
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    function automatic logic sig(input int which);
        return which == 0 ? quiesce_req : which == 1 ? areset_out : which == 2 ? busy : tree_reset;
    endfunction

    task automatic wait_sig(input int which, input logic val, input int limit, output int cycles);
        cycles = 0;
        while (sig(which) !== val) begin
            if (cycles >= limit) begin
                cycles = -1;
                return;
            end
            step;
            cycles++;
        end
    endtask

    task automatic clear_cause;
        cause_clr = 1;
        step;
        cause_clr = 0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 0;
        step;
        repeat (4) sb.push_back(0);
        pop_check("rst_busy", busy);
        pop_check("rst_areset", areset_out);
        pop_check("rst_quiesce", quiesce_req);
        pop_check("rst_cause", cause);

        // software request, ack after a delay, tree follows areset_out
        ack_mode = 1;
        sb.push_back(1); sb.push_back(64); sb.push_back(3); sb.push_back(4'b0001);
        sw_req = 1;
        wait_sig(0, 1, 10, n);
        sw_req = 0;
        pop_check("sw_lat", n);
        wait_sig(1, 1, 30, n);
        wait_sig(1, 0, 200, n);
        pop_check("s1_hold", n);
        wait_sig(3, 0, 20, n);
        wait_sig(2, 0, 20, n);
        pop_check("s1_busy_drop", n);
        pop_check("s1_cause", cause);
        repeat (10) step;

        // watchdog request, quiesce never acknowledged
        ack_mode = 0;
        clear_cause;
        sb.push_back(0); sb.push_back(3); sb.push_back(1024); sb.push_back(4'b1010);
        pop_check("clr", cause);
        wdog_req = 1;
        wait_sig(0, 1, 10, n);
        pop_check("wdog_lat", n);
        wait_sig(1, 1, 1100, n);
        pop_check("tmo_lat", n);
        wait_sig(2, 0, 200, n);
        pop_check("s2_cause", cause);
        wdog_req = 0;
        repeat (10) step;

        // debug level held high: single sequence, then re-toggle
        ack_mode = 1;
        clear_cause;
        s0 = seqs;
        sb.push_back(3); sb.push_back(4'b0100); sb.push_back(0); sb.push_back(1); sb.push_back(2);
        dbg_req = 1;
        wait_sig(0, 1, 10, n);
        pop_check("dbg_lat", n);
        wait_sig(2, 0, 300, n);
        pop_check("s3_cause", cause);
        repeat (20) step;
        pop_check("s3_noretrig_busy", busy);
        pop_check("s3_seqs", seqs - s0);
        dbg_req = 0;
        repeat (5) step;
        dbg_req = 1;
        wait_sig(0, 1, 10, n);
        wait_sig(2, 0, 300, n);
        pop_check("s3_second", seqs - s0);
        dbg_req = 0;
        repeat (10) step;

        // ack already high; requests and clear during ASSERT
        ack_mode = 2;
        clear_cause;
        sb.push_back(1); sb.push_back(4'b0010); sb.push_back(64); sb.push_back(4'b0011);
        sw_req = 1;
        wait_sig(0, 1, 10, n);
        sw_req = 0;
        wait_sig(1, 1, 10, n);
        pop_check("ack_early", n);
        wdog_req = 1;
        step;
        step;
        cause_clr = 1;
        step;
        cause_clr = 0;
        pop_check("clr_vs_set", cause);
        sw_req = 1;
        step;
        sw_req = 0;
        wait_sig(1, 0, 200, n);
        pop_check("s4_hold", n + 4);
        wait_sig(2, 0, 50, n);
        pop_check("s4_cause", cause);
        wdog_req = 0;
        repeat (10) step;

        // dead tree, later released by hand
        tree_auto = 0;
        tree_man = 0;
        sb.push_back(1); sb.push_back(1); sb.push_back(3); sb.push_back(3);
        sw_req = 1;
        wait_sig(0, 1, 10, n);
        sw_req = 0;
        wait_sig(1, 1, 10, n);
        repeat (100) step;
        pop_check("dead_areset", areset_out);
        pop_check("dead_busy", busy);
        tree_man = 1;
        wait_sig(1, 0, 20, n);
        pop_check("late_release", n);
        tree_man = 0;
        wait_sig(2, 0, 20, n);
        pop_check("late_idle", n);
        tree_auto = 1;
        repeat (10) step;

        // asynchronous reset in the middle of ASSERT
        sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(1);
        sw_req = 1;
        wait_sig(0, 1, 10, n);
        sw_req = 0;
        wait_sig(1, 1, 10, n);
        repeat (5) step;
        #2 reset = 1;
        #1;
        pop_check("async_areset", areset_out);
        pop_check("async_cause", cause);
        pop_check("async_busy", busy);
        @(posedge clock);
        #1 reset = 0;
        repeat (5) step;
        pop_check("post_rst_busy", busy);
        sw_req = 1;
        wait_sig(0, 1, 10, n);
        sw_req = 0;
        pop_check("post_rst_sw", n);
        wait_sig(2, 0, 300, n);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
